// File: rtl/word_serializer_pkg.sv
// Shared state encodings and counter-width helpers for the word serializer.
package word_serializer_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StGap   = 2'd2;

    function automatic int unsigned bit_cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    function automatic int unsigned gap_cnt_w(input int unsigned gap);
        return (gap == 0) ? 1 : $clog2(gap + 1);
    endfunction

endpackage

// File: rtl/serial_pend_reg.sv
// One-entry holding register; a write and a read in the same cycle keep it full.
module serial_pend_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full
);

    logic [WIDTH-1:0] data_q;
    logic             full_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            full_q <= 1'b0;
        end else if (wr_en) begin
            full_q <= 1'b1;
        end else if (rd_en) begin
            full_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            data_q <= wr_data;
        end
    end

    assign rd_data = data_q;
    assign full    = full_q;

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial front end: shifts WIDTH-bit words out one bit per cycle with frame markers.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          LSB_FIRST  = 1'b1,
    parameter int unsigned GAP        = 0,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             O,
    output logic             O_valid,
    output logic             O_first,
    output logic             O_last,
    output logic             busy
);

    localparam int unsigned CW = bit_cnt_w(WIDTH);
    localparam int unsigned GW = gap_cnt_w(GAP);
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GapLast = GW'((GAP == 0) ? 0 : GAP - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             o_q, o_d, o_valid_q, o_valid_d, o_first_q, o_first_d, o_last_q, o_last_d;
    logic             accept, last_bit, load_pt;
    logic             pend_wr, pend_rd, pend_full;
    logic [WIDTH-1:0] pend_data;

    serial_pend_reg #(
        .WIDTH(WIDTH)
    ) u_pend (
        .CLK    (CLK),
        .RESET  (RESET),
        .wr_en  (pend_wr),
        .wr_data(in_data),
        .rd_en  (pend_rd),
        .rd_data(pend_data),
        .full   (pend_full)
    );

    assign in_ready = !RESET && !pend_full;
    assign busy     = (state_q != StIdle) || pend_full;

    always_comb begin
        accept   = in_valid && in_ready;
        last_bit = (state_q == StShift) && (cnt_q == CntLast);
        load_pt  = (state_q == StIdle) || (last_bit && (GAP == 0)) ||
                   ((state_q == StGap) && (gap_q == GapLast));
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        shreg_d  = shreg_q;
        pend_rd  = 1'b0;
        // Only a word loaded straight into the shifter bypasses the pending buffer.
        pend_wr  = accept && !(load_pt && !pend_full);
        if (load_pt) begin
            cnt_d = '0;
            gap_d = '0;
            if (pend_full) begin
                pend_rd = 1'b1;
                shreg_d = pend_data;
                state_d = StShift;
            end else if (accept) begin
                shreg_d = in_data;
                state_d = StShift;
            end else begin
                state_d = StIdle;
            end
        end else if (last_bit) begin
            state_d = StGap;
            gap_d   = '0;
        end else if (state_q == StShift) begin
            cnt_d   = cnt_q + CW'(1);
            shreg_d = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], 1'b0};
        end else if (state_q == StGap) begin
            gap_d = gap_q + GW'(1);
        end
    end

    // Outputs are registered from next state so the first bit appears one cycle after load.
    always_comb begin
        o_valid_d = (state_d == StShift);
        o_d       = o_valid_d ? (LSB_FIRST ? shreg_d[0] : shreg_d[WIDTH-1]) : IDLE_LEVEL;
        o_first_d = o_valid_d && (cnt_d == '0);
        o_last_d  = o_valid_d && (cnt_d == CntLast);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            gap_q     <= '0;
            shreg_q   <= '0;
            o_q       <= IDLE_LEVEL;
            o_valid_q <= 1'b0;
            o_first_q <= 1'b0;
            o_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            shreg_q   <= shreg_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
            o_first_q <= o_first_d;
            o_last_q  <= o_last_d;
        end
    end

    assign O       = o_q;
    assign O_valid = o_valid_q;
    assign O_first = o_first_q;
    assign O_last  = o_last_q;

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench: three serializer configurations checked bit-by-bit against a timing model.
module tb_word_serializer;

    typedef struct packed {
        int   cyc;
        logic b;
        logic f;
        logic l;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data [3];
    logic [2:0] in_valid;
    wire  [2:0] in_ready, o, o_valid, o_first, o_last, busy;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         free_at [3];
    bit         mon_en = 1'b0;
    exp_t       exp_q [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    word_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .GAP(0), .IDLE_LEVEL(1'b0)) dut0 (
        .CLK(clk), .RESET(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .O(o[0]), .O_valid(o_valid[0]), .O_first(o_first[0]),
        .O_last(o_last[0]), .busy(busy[0])
    );
    word_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .GAP(2), .IDLE_LEVEL(1'b1)) dut1 (
        .CLK(clk), .RESET(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .O(o[1]), .O_valid(o_valid[1]), .O_first(o_first[1]),
        .O_last(o_last[1]), .busy(busy[1])
    );
    word_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .GAP(0), .IDLE_LEVEL(1'b0)) dut2 (
        .CLK(clk), .RESET(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .O(o[2]), .O_valid(o_valid[2]), .O_first(o_first[2]),
        .O_last(o_last[2]), .busy(busy[2])
    );

    function automatic bit lsb_of(input int k);
        return k != 2;
    endfunction

    function automatic int gap_of(input int k);
        return (k == 1) ? 2 : 0;
    endfunction

    function automatic logic idle_of(input int k);
        return (k == 1) ? 1'b1 : 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Word accepted in cycle t starts at t+1, or when the previous word plus gap is done.
    task automatic push(input int k, input logic [7:0] w, input int t);
        int   start;
        exp_t e;
        start = (t + 1 > free_at[k]) ? t + 1 : free_at[k];
        for (int i = 0; i < 8; i++) begin
            e.cyc = start + i;
            e.b   = lsb_of(k) ? w[i] : w[7-i];
            e.f   = (i == 0);
            e.l   = (i == 7);
            exp_q[k].push_back(e);
        end
        free_at[k] = start + 8 + gap_of(k);
    endtask

    // Leaves in_valid high so the caller can stream consecutive words.
    task automatic send(input int k, input logic [7:0] w, output int t);
        int n;
        n = 0;
        in_data[k]  = w;
        in_valid[k] = 1'b1;
        @(negedge clk);
        while (!in_ready[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        if (!in_ready[k]) begin
            check("ready_timeout", {31'd0, in_ready[k]}, 32'd1);
            in_valid[k] = 1'b0;
        end else begin
            push(k, w, t);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while (exp_q[k].size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("drain%0d", k), exp_q[k].size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                bit   ev;
                exp_t e;
                ev = (exp_q[k].size() > 0) && (exp_q[k][0].cyc == cyc);
                check($sformatf("l%0d_valid", k), {31'd0, o_valid[k]}, {31'd0, ev});
                if (ev) begin
                    e = exp_q[k].pop_front();
                    check($sformatf("l%0d_bit", k), {31'd0, o[k]}, {31'd0, e.b});
                    check($sformatf("l%0d_first", k), {31'd0, o_first[k]}, {31'd0, e.f});
                    check($sformatf("l%0d_last", k), {31'd0, o_last[k]}, {31'd0, e.l});
                end else begin
                    check($sformatf("l%0d_idle", k), {31'd0, o[k]}, {31'd0, idle_of(k)});
                end
            end
        end
    end

    initial begin
        int t0, t1, t2;
        in_valid = 3'b000;
        for (int k = 0; k < 3; k++) begin
            in_data[k] = 8'h00;
            free_at[k] = 0;
        end
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_busy", {29'd0, busy}, 32'd0);
        check("rst_ready", {29'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single word, then back-to-back pair.
        send(0, 8'hA5, t0);
        in_valid[0] = 1'b0;
        drain(0);
        send(0, 8'hA5, t0);
        send(0, 8'h3C, t1);
        in_valid[0] = 1'b0;
        check("b2b_acc", t1, t0 + 1);
        drain(0);

        // Streaming three words: pending fills and in_ready stays low until the load point.
        send(0, 8'h11, t0);
        send(0, 8'hC3, t1);
        in_data[0] = 8'h6E;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("stall_ready", {31'd0, in_ready[0]}, 32'd0);
            check("stall_busy", {31'd0, busy[0]}, 32'd1);
        end
        send(0, 8'h6E, t2);
        in_valid[0] = 1'b0;
        check("w2_acc", t2, t1 + 8);
        drain(0);

        // Gap and idle level of one.
        send(1, 8'hFF, t0);
        send(1, 8'h00, t1);
        in_valid[1] = 1'b0;
        drain(1);

        // MSB-first ordering.
        send(2, 8'h80, t0);
        in_valid[2] = 1'b0;
        drain(2);

        // Reset mid-word with a pending word held.
        send(0, 8'hA5, t0);
        send(0, 8'h3C, t1);
        in_valid[0] = 1'b0;
        check("pend_busy", {31'd0, busy[0]}, 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", {31'd0, in_ready[0]}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_q[k].delete();
            free_at[k] = 0;
        end
        @(negedge clk);
        check("rst_mid_busy", {31'd0, busy[0]}, 32'd0);
        check("rst_mid_valid", {31'd0, o_valid[0]}, 32'd0);
        check("rst_mid_o", {31'd0, o[0]}, 32'd0);
        @(posedge clk);
        #1;
        send(0, 8'h5A, t0);
        in_valid[0] = 1'b0;
        drain(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Parallel-to-serial front end that drives the 1-bit `I` input of the single-bit `Bar`/`Baz` processing chain.
- Accepts `WIDTH`-bit words over a valid/ready handshake, buffers one extra word, and shifts each word out one bit per cycle.
- Emits frame markers (first/last) and inserts an optional fixed idle gap between words.

Parameters:
- WIDTH, 8: word width in bits; must be >= 2.
- LSB_FIRST, 1: 1 = bit 0 is transmitted first; 0 = bit WIDTH-1 is transmitted first.
- GAP, 0: idle cycles inserted after each word; must be >= 0.
- IDLE_LEVEL, 0: value driven on O when no bit is being sent.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- O  output  1  serial bit; connects to the downstream chain input I.
- O_valid  output  1  O carries a data bit.
- O_first  output  1  O carries the first bit of a word.
- O_last  output  1  O carries the last bit of a word.
- busy  output  1  shifter active, in gap, or pending word held.

Behaviour:
- Interface (fixed): one clock, CLK; reset RESET is synchronous and active-high.
- Reset values:
  - O = IDLE_LEVEL; O_valid, O_first, O_last, busy = 0.
  - Pending buffer empty; bit and gap counters = 0; state = IDLE.
  - in_ready = 0 in any cycle where RESET is high.
- Outputs O, O_valid, O_first, O_last are registered.
- in_ready = !RESET && !pend_full (combinational). It does not depend on in_valid.
- Handshake:
  - A word transfers in a cycle where in_valid && in_ready.
  - in_data must be held stable while in_valid is high and in_ready is low.
- Storage: a shift register (the active word) plus a one-entry pending buffer. Words leave strictly in acceptance order.
- Load point: the edge at which the next word is chosen. It occurs at the end of:
  - an IDLE cycle;
  - the last-bit cycle when GAP = 0;
  - the final GAP cycle.
- At the load point:
  - If pending is full, load pending into the shifter and clear pending. A same-cycle accepted word goes into pending.
  - Otherwise, if a word is accepted that cycle, load it directly into the shifter.
  - Otherwise, go to IDLE.
- At any other edge, an accepted word goes into pending.
- State machine:
  - IDLE: O = IDLE_LEVEL, O_valid = 0. On load go to SHIFT.
  - SHIFT: outputs one bit per cycle; bit counter runs 0..WIDTH-1.
    - O_first is high when count = 0; O_last is high when count = WIDTH-1.
    - After the last bit: go to GAP if GAP > 0; otherwise apply the load point (SHIFT again or IDLE).
  - GAP: lasts exactly GAP cycles with O = IDLE_LEVEL and O_valid = 0. Then apply the load point.
- Latency and throughput:
  - Word accepted in cycle t from IDLE: first bit visible at t+1, last bit at t+WIDTH.
  - Back-to-back words with GAP = 0 have no bubble between them.
- Bit order: LSB_FIRST selects a right shift (bit 0 first) or a left shift (bit WIDTH-1 first).
- Counter widths: bit counter is $clog2(WIDTH) bits; gap counter is max(1, $clog2(GAP+1)) bits. Counters reset to 0 at each load and never overflow.
- busy = (state != IDLE) || pend_full.
- Reset mid-word:
  - The active word and pending word are discarded; outputs return to reset values on the next cycle.
  - A partial word is never resumed.

Decomposition:
- Package `word_serializer_pkg`:
  - state enum (IDLE, SHIFT, GAP);
  - helper functions for counter widths.
- One sub-module, `serial_pend_reg`: the one-entry holding register.
  - Ports: CLK, RESET, wr_en, wr_data, rd_en, rd_data, full.
  - Supports write and read in the same cycle.
- The FSM and shifter stay in the top level.

Test Plan:
- WIDTH=8, LSB_FIRST=1, GAP=0; send 0xA5 in cycle 2 -> O = 1,0,1,0,0,1,0,1 in cycles 3-10; O_first in cycle 3, O_last in cycle 10; O_valid=0 and O=0 in cycle 11.
- Same config; send 0xA5 then 0x3C in consecutive cycles -> 0x3C bits 0,0,1,1,1,1,0,0 in cycles 11-18 with no bubble; O_valid continuously high in cycles 3-18.
- Same config; in_valid held with three words from cycle 2 -> W0 and W1 accepted in cycles 2 and 3; in_ready=0 in cycles 4-10; W2 accepted in cycle 11 and first bit at cycle 19.
- GAP=2, IDLE_LEVEL=1; send 0xFF then 0x00 -> ones in cycles 3-10; O=1 with O_valid=0 in cycles 11-12; zeros in cycles 13-20.
- LSB_FIRST=0; send 0x80 -> O = 1 then seven 0s; O_first aligned with the 1.
- RESET high in cycle 6 during 0xA5 with a pending word -> cycle 7: O=0, O_valid=0, busy=0; in_ready=0 in cycle 6; pending word never appears on O; a new word accepted after reset serializes correctly.
